// File: rtl/neural_pkg.sv
// Shared types and fixed-point constants for the neuron multiply-accumulate path.
package neural_pkg;

    localparam int unsigned ACT_W      = 16;
    localparam int unsigned ACT_FRAC   = 8;
    localparam int unsigned ACC_W      = 32;
    localparam int unsigned ACC_FRAC   = 16;
    localparam int unsigned FLOAT_BIAS = 127;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        CONVERT = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ACC_W-1:0] value;
        logic             clamp;
    } sat_t;

    // Signed 32-bit add that clamps to the representable range and reports a clamp.
    function automatic sat_t sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        sat_t           r;
        logic [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            r.clamp = 1'b1;
            r.value = sum[ACC_W] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            r.clamp = 1'b0;
            r.value = sum[ACC_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/q16_to_float.sv
// Combinational Q16.16 to IEEE-754 single conversion, truncating the mantissa.
module q16_to_float
    import neural_pkg::*;
(
    input  logic [ACC_W-1:0] q,
    output logic [31:0]      result_c
);

    logic        sign;
    logic [32:0] mag;
    logic [32:0] norm;
    logic [5:0]  msb;
    logic [7:0]  expo;

    always_comb begin
        sign = q[ACC_W-1];
        // 33 bits so that the most negative input keeps its true magnitude
        mag  = sign ? (~{1'b1, q} + 33'd1) : {1'b0, q};
        msb  = 6'd0;
        for (int i = 0; i < 33; i++) begin
            if (mag[i]) msb = 6'(i);
        end
        norm     = mag << (6'd32 - msb);
        expo     = 8'(int'(FLOAT_BIAS) + int'(msb) - int'(ACC_FRAC));
        result_c = (mag == 33'd0) ? 32'h0000_0000 : {sign, expo, norm[31:9]};
    end

endmodule

// File: rtl/neuron_mac.sv
// Streaming neuron MAC: bias + sum(weight*act) in Q16.16, handed off as IEEE-754 single.
module neuron_mac
    import neural_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_weight,
    input  logic [15:0] in_act,
    input  logic [31:0] in_bias,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_float,
    output logic        out_sat,
    output logic        busy
);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             sat_next;
    logic [31:0]      float_next;
    logic [31:0]      float_c;
    logic [ACC_W-1:0] product;
    sat_t             sum;

    q16_to_float u_conv (
        .q        (acc),
        .result_c (float_c)
    );

    always_comb begin
        product = 32'($signed({{16{in_weight[15]}}, in_weight}) *
                      $signed({{16{in_act[15]}}, in_act}));
    end

    // Next-state and datapath selection
    always_comb begin
        state_next = state;
        acc_next   = acc;
        sat_next   = out_sat;
        float_next = out_float;
        sum        = '0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sum        = sat_add(in_bias, product);
                    acc_next   = sum.value;
                    sat_next   = sum.clamp;
                    state_next = in_last ? CONVERT : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    sum        = sat_add(acc, product);
                    acc_next   = sum.value;
                    sat_next   = out_sat | sum.clamp;
                    state_next = in_last ? CONVERT : ACCUM;
                end
            end
            CONVERT: begin
                float_next = float_c;
                state_next = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    sat_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they align with it
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            out_float <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            out_float <= float_next;
            out_sat   <= sat_next;
            out_valid <= (state_next == OUTPUT);
            in_ready  <= (state_next == IDLE) || (state_next == ACCUM);
            busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac.
module tb_neuron_mac;

    logic        CLOCK_50;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_weight;
    logic [15:0] in_act;
    logic [31:0] in_bias;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_sat;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    neuron_mac dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_weight (in_weight),
        .in_act    (in_act),
        .in_bias   (in_bias),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Present one beat at the negedge, return #1 after the accepting posedge.
    task automatic beat(input logic [31:0] bias, input logic [15:0] w,
                        input logic [15:0] a, input logic last);
        @(negedge CLOCK_50);
        in_valid  = 1'b1;
        in_bias   = bias;
        in_weight = w;
        in_act    = a;
        in_last   = last;
        @(posedge CLOCK_50);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: out_valid timeout got=%0b want=1", name, out_valid);
        end
    endtask

    task automatic transfer();
        @(negedge CLOCK_50);
        out_ready = 1'b1;
        @(posedge CLOCK_50);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
        @(posedge CLOCK_50);
        #1;
        checks++;
        if ({out_valid, in_ready, busy, out_sat} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0100", {out_valid, in_ready, busy, out_sat});
        end
        checks++;
        if (out_float !== 32'h0) begin
            failures++;
            $display("FAIL reset_float got=%h want=00000000", out_float);
        end
    endtask

    task automatic test_single();
        beat(32'h0, 16'h0100, 16'h0200, 1'b1);
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b001) begin
            failures++;
            $display("FAIL single_convert_flags got=%b want=001", {out_valid, in_ready, busy});
        end
        @(posedge CLOCK_50);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_latency got=%b want=1", out_valid);
        end
        checks++;
        if (out_float !== 32'h4000_0000 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL single_value got=%h/%b want=40000000/0", out_float, out_sat);
        end
        transfer();
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL single_idle got=%b want=010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_three_beats();
        beat(32'h0, 16'h0100, 16'h0080, 1'b0);
        beat(32'h0, 16'h0100, 16'hFE80, 1'b0);
        // stall inside ACCUM; nothing should change
        repeat (3) @(posedge CLOCK_50);
        #1;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b110) begin
            failures++;
            $display("FAIL accum_hold got=%b want=110", {in_ready, busy, out_valid});
        end
        out_ready = 1'b1;
        beat(32'h0, 16'h0100, 16'h0040, 1'b1);
        @(posedge CLOCK_50);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_float !== 32'hBF40_0000) begin
            failures++;
            $display("FAIL three_value got=%b/%h want=1/bf400000", out_valid, out_float);
        end
        @(posedge CLOCK_50);
        #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL three_early_ready got=%b want=010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_zero_sum();
        beat(32'h0001_0000, 16'h0100, 16'hFF00, 1'b1);
        wait_valid("zero");
        checks++;
        if (out_float !== 32'h0 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL zero_value got=%h/%b want=00000000/0", out_float, out_sat);
        end
        transfer();
    endtask

    task automatic test_saturation();
        beat(32'h7FFF_0000, 16'h7FFF, 16'h7FFF, 1'b1);
        wait_valid("sat");
        checks++;
        if (out_float !== 32'h46FF_FFFF || out_sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_pos got=%h/%b want=46ffffff/1", out_float, out_sat);
        end
        transfer();
        checks++;
        if (out_sat !== 1'b0) begin
            failures++;
            $display("FAIL sat_clear got=%b want=0", out_sat);
        end
        // negative clamp lands exactly on 0x80000000 -> -32768.0
        beat(32'h8000_0000, 16'h8000, 16'h7FFF, 1'b1);
        wait_valid("sat_neg");
        checks++;
        if (out_float !== 32'hC700_0000 || out_sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg got=%h/%b want=c7000000/1", out_float, out_sat);
        end
        transfer();
    endtask

    task automatic test_backpressure();
        beat(32'h0, 16'h0100, 16'h0300, 1'b1);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            in_valid  = (i % 2) == 0;
            in_last   = 1'b1;
            in_bias   = 32'h0010_0000;
            in_weight = 16'h0100;
            in_act    = 16'h0100;
            @(posedge CLOCK_50);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_float !== 32'h4040_0000) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%b/%b/%h want=1/0/40400000",
                         i, out_valid, in_ready, out_float);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        transfer();
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL bp_release got=%b want=010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_reset_mid_accum();
        beat(32'h7FFF_0000, 16'h7FFF, 16'h7FFF, 1'b0);
        beat(32'h0, 16'h1234, 16'h0456, 1'b0);
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
        checks++;
        if ({out_valid, in_ready, busy, out_sat} !== 4'b0100) begin
            failures++;
            $display("FAIL mid_reset_flags got=%b want=0100", {out_valid, in_ready, busy, out_sat});
        end
        beat(32'h0, 16'h0100, 16'h0200, 1'b1);
        wait_valid("rerun");
        checks++;
        if (out_float !== 32'h4000_0000 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL rerun_value got=%h/%b want=40000000/0", out_float, out_sat);
        end
        transfer();
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_weight = '0;
        in_act    = '0;
        in_bias   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_three_beats();
        test_zero_sum();
        test_saturation();
        test_backpressure();
        test_reset_mid_accum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
